output_writeback: RTL
=====================

Name: output_writeback

Overview:
Downstream stage of the output buffer. Accepts packed 32-bit edge-map words, each paired with its word index, and queues them in a small FIFO. Drains the FIFO to the image SRAM through a req/ack write port, converting each word index to a byte address. Converts the frame-level img_done into a single frame_done pulse once every queued word has been acknowledged by memory.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
BASE_ADDR, 32'h0000_1000, byte address of output image word 0
TIMEOUT_CYCLES, 64, ack wait limit; used only with WB_TIMEOUT_EN

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
word_valid  in  1  upstream has a packed word (from write_out_enable path)
word_data  in  32  packed edge pixels (out_pixel)
word_addr  in  32  word index (write_addr)
word_ready  out  1  FIFO can accept; transfer when word_valid && word_ready
img_done  in  1  single-cycle pulse: last word of frame already offered
mem_wr  out  1  write request to SRAM
mem_addr  out  32  byte address
mem_wdata  out  32  write data
mem_ack  in  1  SRAM accepts current write on this edge
busy  out  1  FIFO non-empty or state != IDLE
frame_done  out  1  one-cycle pulse: all words of the frame written
err  out  1  sticky write timeout (tied 0 without WB_TIMEOUT_EN)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: word_ready=1, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, err=0. FIFO emptied, done_pending=0, state=IDLE.
- word_ready = !fifo_full, computed from registered count. A push is never refused while word_ready=1.
- Push and pop in the same cycle:
  - Both allowed; count is unchanged.
  - When the FIFO is full, word_ready is already 0, so no push occurs.
- Address: mem_addr = BASE_ADDR + {word_addr[29:0],2'b00}, modulo 2^32 (wraps silently). word_addr[31:30] are ignored.
- FSM states: IDLE, WRITE, DONE.
  - IDLE -> WRITE when the FIFO is non-empty. Head entry registered onto mem_addr/mem_wdata; mem_wr=1 next cycle.
  - WRITE:
    - mem_wr=1; addr and data stay stable until mem_ack is sampled high.
    - On mem_ack the head is popped.
    - If the FIFO holds another entry, stay in WRITE with the next head on the next cycle (back-to-back, mem_wr stays 1). Otherwise go to IDLE with mem_wr=0.
  - IDLE -> DONE when done_pending=1 and the FIFO is empty. DONE takes priority only if the FIFO is empty.
  - DONE: frame_done=1 for exactly one cycle, done_pending cleared, then IDLE.
- Write latency: first mem_wr rises 2 cycles after the push edge.
- mem_ack while mem_wr=0 is ignored.
- img_done:
  - Sets done_pending.
  - A second img_done while done_pending=1 is absorbed (single flag).
  - img_done in the same cycle as the final push is legal; frame_done follows that word's ack.
- img_done with an empty FIFO and IDLE state: frame_done 2 cycles later.
- busy is combinational from state and count.
- Reset mid-write: mem_wr low from the next cycle. Queued words and the pending done are discarded; no frame_done.

Optional Feature:
Macro: WB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WRITE and on each ack, and increments each WRITE cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the head is dropped (popped as if acked) and err is set sticky until rst.
  - The FSM then continues as after an ack.
- Undefined: WRITE waits for ack indefinitely; err is constant 0; no counter logic.

Decomposition:
- Package wb_pkg:
  - state enum wb_state_t {IDLE, WRITE, DONE};
  - struct wb_entry_t {addr[31:0], data[31:0]};
  - constant WORD_BYTES=4.
- Sub-module wb_fifo:
  - synchronous FIFO of wb_entry_t, parameterised by DEPTH;
  - push/pop/full/empty/count; sync active-high rst.
- Top holds the FSM, address arithmetic, done_pending and the timeout.

Test Plan:
1. Reset, then idle with no stimulus -> word_ready=1, mem_wr=0, busy=0, frame_done=0, err=0.
2. Push word_addr=5, word_data=32'hFFFF_FFFF, mem_ack tied 1 -> mem_wr=1 with mem_addr=32'h0000_1014 two cycles after push; mem_wr=0 the following cycle.
3. Push 4 words (addr 0-3), mem_ack held 0 -> word_ready=0 after the 4th push. Release ack -> 4 back-to-back writes to 1000/1004/1008/100C with mem_wr continuously 1; then word_ready=1.
4. Push 20 alternating words (32'h0/32'hFFFF_FFFF), img_done on the final push cycle, random ack stalls -> all 20 writes in order; single frame_done after the last ack; busy=0 afterwards.
5. rst asserted during WRITE with 3 entries queued -> mem_wr=0 next cycle; no further writes; no frame_done.
6. WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack held 0 on the first word -> entry dropped after 8 cycles, err=1 and stays 1; the second word is then written normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the output writeback stage.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } wb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wb_entry_t;

    localparam int WORD_BYTES = 4;

    // Word index to byte address; the sum wraps modulo 2^32.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [29:0] idx);
        return base + ({2'b00, idx} << $clog2(WORD_BYTES));
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; exposes the head and the entry behind it
// so the writer can issue back-to-back writes without a bubble.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  wb_entry_t     wr_entry,
    output wb_entry_t     head,
    output wb_entry_t     second,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t         slots [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_next;

    assign rd_ptr_next = PW'(rd_ptr + 1'b1);
    assign head        = slots[rd_ptr];
    assign second      = slots[rd_ptr_next];
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= PW'(wr_ptr + 1'b1);
            if (pop)  rd_ptr <= rd_ptr_next;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/output_writeback.sv
// Queues packed edge-map words and drains them to SRAM over a req/ack port,
// then signals frame_done. Optional write timeout: define WB_TIMEOUT_EN.
module output_writeback
    import wb_pkg::*;
#(
    parameter int          DEPTH          = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    input  logic [31:0] word_addr,
    output logic        word_ready,
    input  logic        img_done,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    localparam int CW = $clog2(DEPTH + 1);

    wb_state_t     state, next_state;
    wb_entry_t     in_entry, head, second;
    logic [CW-1:0] count;
    logic          push, pop, full, empty;
    logic          load_head, load_second;
    logic          done_pending, ack_seen, write_done;
    logic          unused_bits;

    assign word_ready = !full;
    assign push       = word_valid && word_ready;
    assign in_entry   = '{addr: word_byte_addr(BASE_ADDR, word_addr[29:0]), data: word_data};
    assign ack_seen   = mem_wr && mem_ack;
    assign busy       = !empty || (state != IDLE);
    assign frame_done = (state == DONE);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wr_entry (in_entry),
        .head     (head),
        .second   (second),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          timeout, err_flag;

    // Drop on the cycle the counter would reach TIMEOUT_CYCLES.
    assign timeout    = (state == WRITE) && !ack_seen && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign write_done = ack_seen || timeout;
    assign err        = err_flag;
    assign unused_bits = ^word_addr[31:30];

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            if ((state == WRITE) && !ack_seen && !timeout) tmo_cnt <= tmo_cnt + 1'b1;
            else                                           tmo_cnt <= '0;
            if (timeout) err_flag <= 1'b1;
        end
    end
`else
    assign write_done  = ack_seen;
    assign err         = 1'b0;
    assign unused_bits = ^{word_addr[31:30], (TIMEOUT_CYCLES != 0)};
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        load_head   = 1'b0;
        load_second = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    next_state = WRITE;
                    load_head  = 1'b1;
                end else if (done_pending) begin
                    next_state = DONE;
                end
            end
            WRITE: begin
                if (write_done) begin
                    pop = 1'b1;
                    if (count > CW'(1)) load_second = 1'b1;
                    else                next_state  = IDLE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (load_head) begin
            mem_wr    <= 1'b1;
            mem_addr  <= head.addr;
            mem_wdata <= head.data;
        end else if (load_second) begin
            mem_wr    <= 1'b1;
            mem_addr  <= second.addr;
            mem_wdata <= second.data;
        end else if (pop) begin
            mem_wr    <= 1'b0;
        end
    end

    // A new img_done wins over the clear so a back-to-back frame is not lost.
    always_ff @(posedge clk) begin
        if (rst)                done_pending <= 1'b0;
        else if (img_done)      done_pending <= 1'b1;
        else if (state == DONE) done_pending <= 1'b0;
    end

endmodule
